// File: rtl/carousel_scheduler.sv
// carousel_scheduler: collect/rotate/dispense round sequencer driving capture and shift enables of an N-lane carousel
module carousel_scheduler #(
    parameter int NUM_LANES = 3,
    parameter int ROT_W = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] in_valid,
    output logic [NUM_LANES-1:0] in_ready,
    output logic [NUM_LANES-1:0] out_valid,
    input  logic [NUM_LANES-1:0] out_ready,
    input  logic [ROT_W-1:0]     cfg_rot,
    output logic [NUM_LANES-1:0] load_en,
    output logic                 shift_en,
    output logic                 busy,
    output logic [CNT_W-1:0]     rounds_done
);
    typedef enum logic [1:0] {COLLECT, ROTATE, DISPENSE} state_t;
    state_t state, state_nx;
    logic [NUM_LANES-1:0] got, got_nx, sent, sent_nx, out_hs;
    logic [ROT_W-1:0] rot_cnt, rot_cnt_nx;
    logic done;
    // Handshake outputs depend only on state and masks; load_en is the sole in_valid-dependent output.
    always_comb begin
        in_ready = state == COLLECT ? ~got : '0;
        load_en = in_valid & in_ready;
        out_valid = state == DISPENSE ? ~sent : '0;
        out_hs = out_valid & out_ready;
        shift_en = state == ROTATE;
        busy = state != COLLECT;
        state_nx = state;
        got_nx = got | load_en;
        sent_nx = sent | out_hs;
        rot_cnt_nx = rot_cnt;
        done = 1'b0;
        unique case (state)
            COLLECT: if (&(got | load_en)) begin
                rot_cnt_nx = cfg_rot;
                state_nx = cfg_rot != '0 ? ROTATE : DISPENSE;
            end
            ROTATE: begin
                rot_cnt_nx = rot_cnt - 1'b1;
                state_nx = rot_cnt == ROT_W'(1) ? DISPENSE : ROTATE;
            end
            DISPENSE: if (&(sent | out_hs)) begin
                state_nx = COLLECT;
                got_nx = '0;
                sent_nx = '0;
                done = 1'b1;
            end
            default: state_nx = COLLECT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= COLLECT;
            got <= '0;
            sent <= '0;
            rot_cnt <= '0;
            rounds_done <= '0;
        end else begin
            state <= state_nx;
            got <= got_nx;
            sent <= sent_nx;
            rot_cnt <= rot_cnt_nx;
            rounds_done <= rounds_done + CNT_W'(done);
        end
    end
endmodule

// File: tb/tb_carousel_scheduler.sv
// tb_carousel_scheduler: directed rounds with a round-completion scoreboard on rounds_done
module tb_carousel_scheduler;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] in_valid, in_ready, out_valid, out_ready, load_en;
    logic [1:0] cfg_rot;
    logic shift_en, busy;
    logic [1:0] rounds_done;
    int n_cmp = 0;
    int n_err = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_r;
    carousel_scheduler #(.NUM_LANES(3), .ROT_W(2), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .cfg_rot(cfg_rot),
        .load_en(load_en), .shift_en(shift_en), .busy(busy), .rounds_done(rounds_done)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic settle();
        #1;
    endtask
    // A round completes at the edge after every offered lane is accepted; the popped value is checked after it.
    always @(negedge clk) begin
        if (rst === 1'b1 && busy && !shift_en && ((out_valid & ~out_ready) == 3'b000)) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) check("sb_unexpected_round", 32'd1, 32'd0);
            else begin
                exp_r = exp_q.pop_front();
                check("sb_rounds_done", 32'(rounds_done), 32'(exp_r));
                check("sb_in_ready_after", 32'(in_ready), 32'h7);
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end
    initial begin
        logic [2:0] st_iv[6] = '{3'b001, 3'b000, 3'b100, 3'b000, 3'b000, 3'b010};
        logic [2:0] st_ir[6] = '{3'b111, 3'b110, 3'b110, 3'b010, 3'b010, 3'b010};
        rst = 1'b0; in_valid = '0; out_ready = 3'b111; cfg_rot = '0;
        tick(); tick();
        check("rst_in_ready", 32'(in_ready), 32'h7);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_shift", 32'(shift_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rounds", 32'(rounds_done), 32'h0);
        rst = 1'b1;
        tick();
        // basic round, rotate 2
        exp_q.push_back(2'd1);
        in_valid = 3'b111; cfg_rot = 2'd2; settle();
        check("b_load", 32'(load_en), 32'h7);
        tick(); in_valid = 3'b000; settle();
        check("b_shift1", 32'(shift_en), 32'h1);
        check("b_busy", 32'(busy), 32'h1);
        check("b_in_ready_rot", 32'(in_ready), 32'h0);
        tick();
        check("b_shift2", 32'(shift_en), 32'h1);
        tick();
        check("b_shift_off", 32'(shift_en), 32'h0);
        check("b_out_valid", 32'(out_valid), 32'h7);
        tick(); settle();
        check("b_rounds", 32'(rounds_done), 32'h1);
        // staggered collect, rotate 1
        exp_q.push_back(2'd2);
        cfg_rot = 2'd1;
        for (int t = 0; t < 6; t++) begin
            in_valid = st_iv[t]; settle();
            check("s_in_ready", 32'(in_ready), 32'(st_ir[t]));
            check("s_load", 32'(load_en), 32'(st_iv[t] & st_ir[t]));
            check("s_busy", 32'(busy), 32'h0);
            tick();
        end
        in_valid = 3'b000; settle();
        check("s_rot_t6", 32'(shift_en), 32'h1);
        tick();
        check("s_out_valid", 32'(out_valid), 32'h7);
        tick();
        // rotate 1 while cfg_rot jumps to 3 mid-round
        exp_q.push_back(2'd3);
        in_valid = 3'b111; cfg_rot = 2'd1; settle();
        tick(); in_valid = 3'b000; cfg_rot = 2'd3; settle();
        check("c_shift", 32'(shift_en), 32'h1);
        tick();
        check("c_one_shift", 32'(shift_en), 32'h0);
        check("c_out_valid", 32'(out_valid), 32'h7);
        tick();
        // cfg_rot 0 skips ROTATE; counter wraps
        exp_q.push_back(2'd0);
        in_valid = 3'b111; cfg_rot = 2'd0; settle();
        tick(); in_valid = 3'b000; settle();
        check("z_no_shift", 32'(shift_en), 32'h0);
        check("z_out_valid", 32'(out_valid), 32'h7);
        tick(); settle();
        check("z_wrap", 32'(rounds_done), 32'h0);
        // backpressure then one lane per cycle
        exp_q.push_back(2'd1);
        out_ready = 3'b000; in_valid = 3'b111; settle();
        tick(); in_valid = 3'b000;
        for (int i = 0; i < 10; i++) begin
            settle();
            check("p_hold", 32'(out_valid), 32'h7);
            tick();
        end
        out_ready = 3'b001; settle();
        check("p_v0", 32'(out_valid), 32'h7);
        tick(); out_ready = 3'b010; settle();
        check("p_v1", 32'(out_valid), 32'h6);
        tick(); out_ready = 3'b100; settle();
        check("p_v2", 32'(out_valid), 32'h4);
        check("p_rounds_hold", 32'(rounds_done), 32'h0);
        tick(); out_ready = 3'b111; settle();
        check("p_rounds", 32'(rounds_done), 32'h1);
        // reset during ROTATE abandons the round
        in_valid = 3'b111; cfg_rot = 2'd3; settle();
        tick(); in_valid = 3'b000; settle();
        check("r_shift", 32'(shift_en), 32'h1);
        rst = 1'b0;
        tick();
        check("r_shift_off", 32'(shift_en), 32'h0);
        check("r_in_ready", 32'(in_ready), 32'h7);
        check("r_rounds", 32'(rounds_done), 32'h0);
        check("r_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        tick();
        // recovery round after reset
        exp_q.push_back(2'd1);
        in_valid = 3'b111; cfg_rot = 2'd2; settle();
        check("v_load", 32'(load_en), 32'h7);
        tick(); in_valid = 3'b000;
        tick(); tick(); tick(); tick();
        check("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/carousel_scheduler.md
Name: carousel_scheduler

Overview:
- Control sequencer for an N-lane rotating register buffer (carousel).
- Runs a three-phase round:
  - collect one word per lane through per-lane valid/ready;
  - issue a programmable number of rotate strobes;
  - release all lanes downstream through per-lane valid/ready.
- Drives only the capture and shift enables of the datapath registers; carries no data.

Parameters:
- NUM_LANES, 3, number of carousel lanes/registers.
- ROT_W, 2, width of rotation-amount config; max rotation per round is 2**ROT_W-1.
- CNT_W, 16, width of completed-round counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-low (asserted when 0).
- in_valid  input  NUM_LANES  per-lane upstream valid.
- in_ready  output  NUM_LANES  per-lane upstream ready.
- out_valid  output  NUM_LANES  per-lane downstream valid.
- out_ready  input  NUM_LANES  per-lane downstream ready.
- cfg_rot  input  ROT_W  rotate steps per round; sampled once per round.
- load_en  output  NUM_LANES  capture strobe to lane register i.
- shift_en  output  1  rotate-by-one strobe to carousel.
- busy  output  1  high in ROTATE or DISPENSE.
- rounds_done  output  CNT_W  count of completed rounds, wraps modulo 2**CNT_W.

Behaviour:
- Reset (rst==0 at posedge):
  - state=COLLECT; got/sent masks cleared; rot_cnt=0; rounds_done=0.
  - Outputs go to their COLLECT values: in_ready all 1, out_valid 0, load_en 0, shift_en 0, busy 0.
  - Reset mid-round abandons the round; no partial strobes after reset.
- Internal state: got[NUM_LANES], sent[NUM_LANES], rot_cnt[ROT_W], rot_amt latch.
- COLLECT:
  - in_ready[i] = ~got[i] (combinational from registered mask).
  - load_en[i] = in_valid[i] & in_ready[i], same cycle; handshake sets got[i] at the edge.
  - Lanes complete independently; a lane already captured ignores in_valid until the next round.
  - Exit when (got | load_en) is all-ones:
    - cfg_rot sampled that cycle into rot_amt/rot_cnt;
    - next state ROTATE if cfg_rot!=0, else DISPENSE.
  - out_valid=0, shift_en=0.
- ROTATE:
  - shift_en=1 every cycle; rot_cnt decrements.
  - When rot_cnt==1 this cycle, next state is DISPENSE.
  - Exactly rot_amt consecutive shift_en cycles.
  - in_ready=0, out_valid=0, load_en=0.
  - cfg_rot changes during ROTATE have no effect.
- DISPENSE:
  - out_valid[i] = ~sent[i]; out_valid[i] & out_ready[i] sets sent[i].
  - When (sent | handshakes) is all-ones:
    - next state COLLECT;
    - got and sent cleared;
    - rounds_done increments.
  - in_ready=0, shift_en=0.
  - out_valid[i] never drops without the lane's handshake.
- Latency:
  - Best-case round = 1 COLLECT cycle + rot_amt ROTATE cycles + 1 DISPENSE cycle.
  - First in_ready after the final dispense handshake comes the next cycle.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.
  - in_ready/out_valid depend on state and masks only.
  - load_en is the only in_valid-dependent output.
- Simultaneous events: the last lane's handshake and the phase exit occur in the same cycle; no bubble cycle.
- busy = (state==ROTATE) | (state==DISPENSE).

Test Plan:
- Reset then all in_valid=3'b111 with cfg_rot=2, out_ready=3'b111:
  - cycle 0: load_en=111.
  - cycles 1-2: shift_en=1.
  - cycle 3: out_valid=111.
  - cycle 4: in_ready=111, rounds_done=1.
- Staggered inputs: in_valid lane0 at t0, lane2 at t2, lane1 at t5:
  - each load_en pulses exactly once;
  - in_ready[i] drops after its own handshake;
  - ROTATE starts at t6.
- cfg_rot=0:
  - COLLECT goes directly to DISPENSE;
  - shift_en never asserts;
  - cfg_rot toggled to 3 during ROTATE of a prior round=1 gives exactly 1 shift.
- Backpressure: out_ready held 000 for 10 cycles, then lanes released one per cycle:
  - out_valid stays 111 with no drops;
  - clears per lane;
  - rounds_done increments only after the third handshake.
- rst=0 asserted in the middle of ROTATE (cfg_rot=3, after 1 shift):
  - next cycle shift_en=0, in_ready=111, rounds_done=0, busy=0.
- CNT_W=2, run 5 rounds -> rounds_done sequence 1,2,3,0,1.
